// File: rtl/mult_booth_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_booth_seq
//  Description : Sequential radix-2 Booth multiplier, one product bit per
//                clock over a (2*WIDTH+1)-bit product state.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_booth_seq #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 data_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic [WIDTH-1:0]     result,
   output logic                 overflow
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [2*WIDTH:0]     r_p;
   logic [WIDTH-1:0]     r_m;
   logic [CNT_W-1:0]     r_count;
   logic                 r_busy;
   logic                 r_data_ready;

   logic [WIDTH-1:0]     w_a;
   logic [WIDTH:0]       w_a_ext;
   logic [WIDTH:0]       w_m_ext;
   logic [WIDTH:0]       w_u;
   logic [2*WIDTH:0]     w_p_next;
   logic [WIDTH:0]       w_hi;
   logic                 w_accept;

   assign w_a      = r_p[2*WIDTH:WIDTH+1];
   assign w_a_ext  = {w_a[WIDTH-1], w_a};
   assign w_m_ext  = {r_m[WIDTH-1], r_m};
   assign w_accept = start && (r_state != RUN);

   // The upper sum is one bit wider than A so that M = most-negative still
   // produces the right sign bit before the arithmetic shift.
   always_comb begin
      w_u = w_a_ext;
      case (r_p[1:0])
         2'b01:   w_u = w_a_ext + w_m_ext;
         2'b10:   w_u = w_a_ext - w_m_ext;
         default: w_u = w_a_ext;
      endcase
   end

   assign w_p_next = {w_u, r_p[WIDTH:1]};

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state      <= IDLE;
         r_p          <= '0;
         r_m          <= '0;
         r_count      <= '0;
         r_busy       <= 1'b0;
         r_data_ready <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               r_p     <= w_p_next;
               r_count <= r_count + CNT_W'(1);
               if (r_count == c_last_iter) begin
                  r_state      <= DONE;
                  r_busy       <= 1'b0;
                  r_data_ready <= 1'b1;
               end
            end
            default: begin
               r_data_ready <= 1'b0;
               if (w_accept) begin
                  r_p     <= {{WIDTH{1'b0}}, multiplier, 1'b0};
                  r_m     <= multiplicand;
                  r_count <= '0;
                  r_state <= RUN;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

   // Product fits in WIDTH signed bits only if P[2W:W] is a pure sign extension.
   assign w_hi       = r_p[2*WIDTH:WIDTH];
   assign overflow   = !((w_hi == '0) || (w_hi == '1));
   assign busy       = r_busy;
   assign data_ready = r_data_ready;
   assign product    = r_p[2*WIDTH:1];
   assign result     = r_p[WIDTH:1];

endmodule
`default_nettype wire

// File: tb/tb_mult_booth_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_booth_seq
//  Description : Directed self-checking bench for mult_booth_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_booth_seq;

   logic        clk;
   logic        clr;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        busy;
   logic        data_ready;
   logic [63:0] product;
   logic [31:0] result;
   logic        overflow;

   int errors = 0;
   int checks = 0;
   int dr_pulses = 0;

   mult_booth_seq #(.WIDTH(32)) u_dut (
      .clk          (clk),
      .clr          (clr),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .data_ready   (data_ready),
      .product      (product),
      .result       (result),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (data_ready) dr_pulses++;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Presents operands and a one-cycle start; returns at the negedge after E0.
   task automatic start_op(input logic [31:0] m, input logic [31:0] q);
      @(negedge clk);
      start = 1'b1;
      multiplicand = m;
      multiplier = q;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts negedges until data_ready is seen, bounded.
   task automatic wait_done(input int already, output int n);
      n = already;
      while (!data_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", {63'd0, data_ready}, 64'd1);
   endtask

   task automatic check_result(input string tag, input logic [63:0] p, input logic [31:0] r,
                               input logic ov);
      check({tag, "_product"}, product, p);
      check({tag, "_result"}, {32'd0, result}, {32'd0, r});
      check({tag, "_overflow"}, {63'd0, overflow}, {63'd0, ov});
   endtask

   initial begin
      int n;
      int pulses0;
      clr = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier = '0;

      repeat (2) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_ready", {63'd0, data_ready}, 64'd0);
      check_result("rst", 64'd0, 32'd0, 1'b0);
      clr = 1'b1;

      // 3 * -4 = -12; data_ready 32 negedges after the one following E0
      start_op(32'd3, 32'hFFFF_FFFC);
      check("run_busy", {63'd0, busy}, 64'd1);
      wait_done(0, n);
      check("latency", 64'(n), 64'd32);
      check("done_busy", {63'd0, busy}, 64'd0);
      check_result("m3q-4", 64'hFFFF_FFFF_FFFF_FFF4, 32'hFFFF_FFF4, 1'b0);
      @(negedge clk);
      check("pulse_width", {63'd0, data_ready}, 64'd0);
      check("hold_result", {32'd0, result}, 64'h0000_0000_FFFF_FFF4);

      start_op(32'h8000_0000, 32'h8000_0000);
      wait_done(0, n);
      check_result("minxmin", 64'h4000_0000_0000_0000, 32'h0, 1'b1);

      start_op(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(0, n);
      check_result("minxm1", 64'h0000_0000_8000_0000, 32'h8000_0000, 1'b1);

      start_op(32'h7FFF_FFFF, 32'd2);
      wait_done(0, n);
      check_result("maxx2", 64'h0000_0000_FFFF_FFFE, 32'hFFFF_FFFE, 1'b1);

      start_op(32'd0, 32'h1234_5678);
      wait_done(0, n);
      check_result("zero", 64'd0, 32'd0, 1'b0);

      // start pulse while running must be ignored
      @(negedge clk);
      pulses0 = dr_pulses;
      start_op(32'd7, 32'd6);
      repeat (8) @(negedge clk);
      start = 1'b1;
      multiplicand = 32'd9;
      multiplier = 32'd9;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      wait_done(10, n);
      check("ignore_latency", 64'(n), 64'd32);
      check_result("7x6", 64'd42, 32'd42, 1'b0);
      repeat (40) @(negedge clk);
      check("ignore_one_pulse", 64'(dr_pulses - pulses0), 64'd1);

      // back-to-back accept in the DONE cycle
      start_op(32'd2, 32'd3);
      wait_done(0, n);
      check("b2b_first", {32'd0, result}, 64'd6);
      start = 1'b1;
      multiplicand = 32'd5;
      multiplier = 32'hFFFF_FFFB;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", {63'd0, busy}, 64'd1);
      wait_done(0, n);
      check("b2b_latency", 64'(n), 64'd32);
      check_result("5x-5", 64'hFFFF_FFFF_FFFF_FFE7, 32'hFFFF_FFE7, 1'b0);

      // asynchronous reset mid-operation
      @(negedge clk);
      pulses0 = dr_pulses;
      start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
      repeat (15) @(negedge clk);
      #2 clr = 1'b0;
      #1;
      check("arst_busy", {63'd0, busy}, 64'd0);
      check("arst_ready", {63'd0, data_ready}, 64'd0);
      check_result("arst", 64'd0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      clr = 1'b1;
      repeat (40) @(negedge clk);
      check("arst_no_pulse", 64'(dr_pulses - pulses0), 64'd0);

      start_op(32'd4, 32'd4);
      wait_done(0, n);
      check_result("4x4", 64'd16, 32'd16, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
